gh_fifo_sync_sr_p: RTL and testbench

- Parametrised single-clock FIFO; next generation of the gh_ async 16-deep FIFO.
- Depth is set by add_width (2^add_width entries) instead of a fixed 16.
- Adds an occupancy count, programmable almost-full/almost-empty flags and a synchronous soft reset.
- Used where producer and consumer share one clock domain: datapath buffering, UART/SPI staging.

---
 rtl/gh_fifo_pkg.sv | 19 +
 rtl/gh_fifo_ptr.sv | 32 +++
 rtl/gh_fifo_sync_sr_p.sv | 137 +++++++++++++
 tb/tb_gh_fifo_sync_sr_p.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gh_fifo_pkg.sv
// Shared definitions for the gh_fifo family.
//   depth_f   : number of FIFO entries for a given address width (2**add_width)
//   range_ok  : inclusive range test used by the parameter checks
//   Default widths used when a FIFO is instantiated without overrides.
package gh_fifo_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultAddWidth  = 4;

  function automatic int unsigned depth_f(input int unsigned add_width);
    return 32'd1 << add_width;
  endfunction

  function automatic bit range_ok(input int unsigned v, input int unsigned lo,
                                  input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/gh_fifo_ptr.sv
// (add_width+1)-bit FIFO pointer. The MSB is a wrap bit; the pointer wraps by
// natural overflow.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the pointer
//   srst  : synchronous soft reset, clears the pointer (priority over ce)
//   ce    : advance the pointer by one
//   ptr   : current pointer value
module gh_fifo_ptr #(
  parameter int unsigned add_width = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               srst,
  input  logic               ce,
  output logic [add_width:0] ptr
);

  logic [add_width:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (srst) begin
      ptr_q <= '0;
    end else if (ce) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/gh_fifo_sync_sr_p.sv
// Parametrised single-clock show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty flags and synchronous soft reset.
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   srst         : synchronous soft reset, clears pointers and count
//   WR, D        : write request and write data (ignored while full)
//   RD           : read request (ignored while empty)
//   Q            : head entry, combinational from memory (zero read latency)
//   count        : stored entries, 0..2**add_width
//   empty, full, almost_empty, almost_full : decodes of the registered count
// Optional macro GH_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs,
// cleared by srst or rst_n.
module gh_fifo_sync_sr_p
  import gh_fifo_pkg::*;
#(
  parameter int unsigned data_width = DefaultDataWidth,
  parameter int unsigned add_width  = DefaultAddWidth,
  parameter int unsigned af_level   = 12,
  parameter int unsigned ae_level   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  WR,
  input  logic                  RD,
  input  logic [data_width-1:0] D,
  output logic [data_width-1:0] Q,
  output logic [add_width:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full
`ifdef GH_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned Depth = depth_f(add_width);
  localparam logic [add_width:0] DepthC   = Depth[add_width:0];
  localparam logic [add_width:0] AfLevelC = af_level[add_width:0];
  localparam logic [add_width:0] AeLevelC = ae_level[add_width:0];

  if (!range_ok(add_width, 2, 12)) begin : g_bad_add_width
    $error("gh_fifo_sync_sr_p: add_width out of range 2..12");
  end
  if (!range_ok(af_level, 1, Depth)) begin : g_bad_af_level
    $error("gh_fifo_sync_sr_p: af_level out of range 1..depth");
  end
  if (!range_ok(ae_level, 0, Depth - 1)) begin : g_bad_ae_level
    $error("gh_fifo_sync_sr_p: ae_level out of range 0..depth-1");
  end

  logic [data_width-1:0] mem [Depth];
  logic [add_width:0]    add_WR, add_RD;
  logic [add_width:0]    count_q, count_d;
  logic                  wr_ce, rd_ce;

  // srst blocks both ports so a soft reset never writes memory.
  assign wr_ce = WR && !full  && !srst;
  assign rd_ce = RD && !empty && !srst;

  gh_fifo_ptr #(.add_width(add_width)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (srst),
    .ce    (wr_ce),
    .ptr   (add_WR)
  );

  gh_fifo_ptr #(.add_width(add_width)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (srst),
    .ce    (rd_ce),
    .ptr   (add_RD)
  );

  // Occupancy comes from count, so the pointer wrap bits are not needed here.
  logic unused_ptr_msb;
  assign unused_ptr_msb = add_WR[add_width] ^ add_RD[add_width];

  // Memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ce) begin
      mem[add_WR[add_width-1:0]] <= D;
    end
  end

  assign Q = mem[add_RD[add_width-1:0]];

  always_comb begin
    count_d = count_q;
    case ({wr_ce, rd_ce})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthC);
  assign almost_empty = (count_q <= AeLevelC);
  assign almost_full  = (count_q >= AfLevelC);

`ifdef GH_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (srst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (WR && full)  overflow_q  <= 1'b1;
      if (RD && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_gh_fifo_sync_sr_p.sv
module tb_gh_fifo_sync_sr_p;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          srst;
  logic          WR;
  logic          RD;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic [AW:0]   count;
  logic          empty, full, almost_empty, almost_full;
`ifdef GH_FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
  bit            m_ovf, m_udf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a plain queue of stored bytes.
  logic [DW-1:0] model_q[$];

  gh_fifo_sync_sr_p #(
    .data_width (DW),
    .add_width  (AW),
    .af_level   (AF),
    .ae_level   (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .srst         (srst),
    .WR           (WR),
    .RD           (RD),
    .D            (D),
    .Q            (Q),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
`ifdef GH_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ":count"}, 32'(count), 32'(n));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ":afull"}, 32'(almost_full), 32'(n >= AF));
    if (n > 0) chk({tag, ":Q"}, 32'(Q), 32'(model_q[0]));
`ifdef GH_FIFO_ERR_FLAGS_EN
    chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":udf"}, 32'(underflow), 32'(m_udf));
`endif
  endtask

  // One clock: drive, update model with the rules, then check 1 time unit after the edge.
  task automatic step(input string tag, input bit wr, input bit rd,
                      input logic [DW-1:0] d, input bit sr);
    bit was_full, was_empty;
    WR = wr; RD = rd; D = d; srst = sr;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    @(posedge clk);
    if (sr) begin
      model_q.delete();
`ifdef GH_FIFO_ERR_FLAGS_EN
      m_ovf = 0; m_udf = 0;
`endif
    end else begin
      if (rd && !was_empty) void'(model_q.pop_front());
      if (wr && !was_full) model_q.push_back(d);
`ifdef GH_FIFO_ERR_FLAGS_EN
      if (wr && was_full) m_ovf = 1;
      if (rd && was_empty) m_udf = 1;
`endif
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int peak;
    logic [DW-1:0] v;
    rst_n = 1'b0; srst = 1'b0; WR = 1'b0; RD = 1'b0; D = '0;
`ifdef GH_FIFO_ERR_FLAGS_EN
    m_ovf = 0; m_udf = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");

    // Fill 0x00..0x0F, then a 17th write that must be dropped.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, DW'(i), 0);
    step("fill_over", 1, 0, 8'hFF, 0);

    // Drain: Q must walk 0x00..0x0F, then an extra read on empty.
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_head", 32'(Q), 32'(i));
      step("drain", 0, 1, '0, 0);
    end
    step("drain_under", 0, 1, '0, 0);

    // Wrap: 40 write/read bursts of 5 from 0xA0 upward.
    v = 8'hA0;
    peak = 0;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 5; i++) begin
        step("wrap_wr", 1, 0, v, 0);
        v = v + 1'b1;
        if (int'(count) > peak) peak = int'(count);
      end
      for (int i = 0; i < 5; i++) step("wrap_rd", 0, 1, '0, 0);
    end
    chk("wrap_peak", 32'(peak), 32'd5);

    // Simultaneous read/write at count 7, at empty and at full.
    for (int i = 0; i < 7; i++) step("sim_fill7", 1, 0, DW'(8'h30 + i), 0);
    for (int i = 0; i < 10; i++) step("sim_rw7", 1, 1, DW'(8'h50 + i), 0);
    while (model_q.size() > 0) step("sim_drain", 0, 1, '0, 0);
    step("sim_rw_empty", 1, 1, 8'h77, 0);
    chk("sim_rw_empty_q", 32'(Q), 32'h77);
    while (model_q.size() < DEPTH) step("sim_fill16", 1, 0, DW'($urandom), 0);
    step("sim_rw_full", 1, 1, 8'h99, 0);
    chk("sim_rw_full_cnt", 32'(count), 32'd15);

    // Soft reset at count 9 with a write pending.
    while (model_q.size() > 9) step("sr_trim", 0, 1, '0, 0);
    step("srst_wr", 1, 0, 8'hEE, 1);
    chk("srst_cnt", 32'(count), 32'd0);
    step("post_srst_rd", 0, 1, '0, 0);
    step("post_srst_clr", 0, 0, '0, 1);
    step("post_srst_wr", 1, 0, 8'h5A, 0);

    // Random traffic with occasional soft reset.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom), 1'($urandom), DW'($urandom), ($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset between edges clears state with no clock edge.
    while (model_q.size() < 6) step("arst_fill", 1, 0, DW'($urandom), 0);
    WR = 1'b0; RD = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
`ifdef GH_FIFO_ERR_FLAGS_EN
    m_ovf = 0; m_udf = 0;
`endif
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_arst_wr", 1, 0, 8'h3C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
